ps2_scancode_decoder: RTL and testbench

Decodes the raw PS/2 set-2 scancode stream from the keyboard receiver's FIFO into key events, with make/break, extended-prefix and modifier state, and ASCII for a fixed key subset. Events queue in an 8-deep FIFO that the CPU reads over the STB/ACK bus; INT signals pending events. The block sits directly downstream of the receiver: it watches its `ready`, reads its `data`, and pops it with a one-cycle active-low `rdn` pulse.

---
 rtl/ps2_scancode_decoder.sv | 232 +++++++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode decoder. Pulls raw codes from the receiver FIFO,
// tracks break/extended prefixes and modifier keys, translates a fixed key
// subset to ASCII and queues one event word per key into a small FIFO that
// the CPU drains over a STB/ACK bus.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_clrn,
  input  logic [7:0]  i_code_in,
  input  logic        i_code_ready,
  output logic        o_code_rdn,
  input  logic        i_stb,
  input  logic        i_we,
  input  logic [31:0] i_din,
  output logic        o_ack,
  output logic [31:0] o_dat,
  output logic        o_int
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    DECODE = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_latch;
  logic [7:0]  r_code;
  logic        r_ext;
  logic        r_brk;
  logic        r_lshift;
  logic        r_rshift;
  logic        r_ctrl;
  logic        r_alt;
  logic        r_caps;
  logic        r_stb_q;
  logic        r_ie;

  logic [21:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic        w_empty;
  logic        w_full;
  logic        w_is_ext;
  logic        w_is_brk;
  logic        w_is_ignore;
  logic        w_is_event;
  logic        w_decoding;
  logic        w_lshift_n;
  logic        w_rshift_n;
  logic        w_ctrl_n;
  logic        w_alt_n;
  logic        w_caps_n;
  logic        w_shift_n;
  logic [7:0]  w_letter;
  logic [7:0]  w_other;
  logic [7:0]  w_ascii;
  logic [21:0] w_event;
  logic        w_rd;
  logic        w_wr;
  logic        w_flush;
  logic        w_push;
  logic        w_pop;
  logic        w_unused_din;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  // Next-state logic and receiver pop strobe
  always_comb begin
    w_state_next = r_state;
    o_code_rdn   = 1'b1;
    w_latch      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_code_ready && !w_full) begin
          w_latch      = 1'b1;
          w_state_next = POP;
        end
      end
      POP: begin
        o_code_rdn   = 1'b0;
        w_state_next = DECODE;
      end
      DECODE:  w_state_next = SETTLE;
      SETTLE:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_clrn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Code classification and post-update modifier values
  assign w_decoding  = (r_state == DECODE);
  assign w_is_ext    = (r_code == 8'hE0);
  assign w_is_brk    = (r_code == 8'hF0);
  assign w_is_ignore = (r_code == 8'hE1) || (r_code == 8'hAA) || (r_code == 8'hFA) ||
                       (r_code == 8'hEE) || (r_code == 8'hFE) || (r_code == 8'h00) ||
                       (r_code == 8'hFF);
  assign w_is_event  = !(w_is_ext || w_is_brk || w_is_ignore);

  assign w_lshift_n = (r_code == 8'h12) ? ~r_brk : r_lshift;
  assign w_rshift_n = (r_code == 8'h59) ? ~r_brk : r_rshift;
  assign w_ctrl_n   = (r_code == 8'h14) ? ~r_brk : r_ctrl;
  assign w_alt_n    = (r_code == 8'h11) ? ~r_brk : r_alt;
  assign w_caps_n   = (r_code == 8'h58 && !r_brk && !r_ext) ? ~r_caps : r_caps;
  assign w_shift_n  = w_lshift_n | w_rshift_n;

  // Lowercase letter / fixed-character lookup for the ASCII subset
  always_comb begin
    w_letter = 8'h00;
    w_other  = 8'h00;
    case (r_code)
      8'h1C: w_letter = 8'h61;  8'h32: w_letter = 8'h62;  8'h21: w_letter = 8'h63;
      8'h23: w_letter = 8'h64;  8'h24: w_letter = 8'h65;  8'h2B: w_letter = 8'h66;
      8'h34: w_letter = 8'h67;  8'h33: w_letter = 8'h68;  8'h43: w_letter = 8'h69;
      8'h3B: w_letter = 8'h6A;  8'h42: w_letter = 8'h6B;  8'h4B: w_letter = 8'h6C;
      8'h3A: w_letter = 8'h6D;  8'h31: w_letter = 8'h6E;  8'h44: w_letter = 8'h6F;
      8'h4D: w_letter = 8'h70;  8'h15: w_letter = 8'h71;  8'h2D: w_letter = 8'h72;
      8'h1B: w_letter = 8'h73;  8'h2C: w_letter = 8'h74;  8'h3C: w_letter = 8'h75;
      8'h2A: w_letter = 8'h76;  8'h1D: w_letter = 8'h77;  8'h22: w_letter = 8'h78;
      8'h35: w_letter = 8'h79;  8'h1A: w_letter = 8'h7A;
      8'h45: w_other = 8'h30;   8'h16: w_other = 8'h31;   8'h1E: w_other = 8'h32;
      8'h26: w_other = 8'h33;   8'h25: w_other = 8'h34;   8'h2E: w_other = 8'h35;
      8'h36: w_other = 8'h36;   8'h3D: w_other = 8'h37;   8'h3E: w_other = 8'h38;
      8'h46: w_other = 8'h39;
      8'h29: w_other = 8'h20;   8'h5A: w_other = 8'h0D;   8'h66: w_other = 8'h08;
      8'h76: w_other = 8'h1B;   8'h0D: w_other = 8'h09;
      default: ;
    endcase
  end

  // Letters shift to uppercase by clearing bit 5; breaks and E0 keys carry no ASCII
  assign w_ascii = (r_brk || r_ext) ? 8'h00 :
                   (w_letter != 8'h00) ? ((w_shift_n ^ w_caps_n) ? (w_letter & 8'hDF) : w_letter) :
                   w_other;

  assign w_event = {w_caps_n, w_alt_n, w_ctrl_n, w_shift_n, r_ext, r_brk, w_ascii, r_code};

  // Bus strobes act on the rising edge of STB only, so long strobes pop once
  assign w_rd    = i_stb && !i_we && !r_stb_q;
  assign w_wr    = i_stb && i_we && !r_stb_q;
  assign w_flush = w_wr && i_din[0];
  assign w_push  = w_decoding && w_is_event && !w_flush;
  assign w_pop   = w_rd && !w_empty;
  assign w_unused_din = ^i_din[31:2];

  // Code latch, prefix and modifier state, bus control registers
  always_ff @(posedge i_clk) begin
    if (!i_clrn) begin
      r_code   <= 8'h00;
      r_ext    <= 1'b0;
      r_brk    <= 1'b0;
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_ctrl   <= 1'b0;
      r_alt    <= 1'b0;
      r_caps   <= 1'b0;
      r_stb_q  <= 1'b0;
      r_ie     <= 1'b0;
    end else begin
      r_stb_q <= i_stb;
      if (w_wr) begin
        r_ie <= i_din[1];
      end
      if (w_latch) begin
        r_code <= i_code_in;
      end
      if (w_decoding) begin
        if (w_is_ext) begin
          r_ext <= 1'b1;
        end else if (w_is_brk) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (w_is_event) begin
            r_lshift <= w_lshift_n;
            r_rshift <= w_rshift_n;
            r_ctrl   <= w_ctrl_n;
            r_alt    <= w_alt_n;
            r_caps   <= w_caps_n;
          end
        end
      end
    end
  end

  // Event storage; contents need no reset since occupancy is tracked separately
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_event;
    end
  end

  // FIFO pointers and occupancy; flush overrides a simultaneous push or pop
  always_ff @(posedge i_clk) begin
    if (!i_clrn || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  assign o_ack = i_stb;
  assign o_dat = w_empty ? 32'h0 : {1'b1, 9'b0, r_mem[r_rd_ptr]};
  assign o_int = r_ie && !w_empty;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: models the upstream receiver FIFO
// as a queue, feeds scancode sequences and checks the queued event words.
module tb_ps2_scancode_decoder;

  logic        clk = 1'b0;
  logic        clrn;
  logic [7:0]  code_in;
  logic        code_ready;
  logic        code_rdn;
  logic        stb;
  logic        we;
  logic [31:0] din;
  logic        ack;
  logic [31:0] dat;
  logic        int_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  logic [7:0] rx_q [$];

  logic [7:0]  burst_codes [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
  logic [31:0] burst_evts  [9] = '{32'h8000_611C, 32'h8000_6232, 32'h8000_6321, 32'h8000_6423,
                                   32'h8000_6524, 32'h8000_662B, 32'h8000_6734, 32'h8000_6833,
                                   32'h8000_6943};

  ps2_scancode_decoder #(.FIFO_DEPTH(8)) dut (
    .i_clk        (clk),
    .i_clrn       (clrn),
    .i_code_in    (code_in),
    .i_code_ready (code_ready),
    .o_code_rdn   (code_rdn),
    .i_stb        (stb),
    .i_we         (we),
    .i_din        (din),
    .o_ack        (ack),
    .o_dat        (dat),
    .o_int        (int_o)
  );

  always #5 clk = ~clk;

  task automatic rx_drive();
    code_ready = (rx_q.size() != 0);
    code_in    = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  endtask

  // Receiver model: the pop strobe removes the head before the next rising edge
  always @(negedge clk) begin
    if (code_rdn === 1'b0 && rx_q.size() != 0) begin
      void'(rx_q.pop_front());
      n_pops++;
      rx_drive();
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] c);
    rx_q.push_back(c);
    rx_drive();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && rx_q.size() != 0; i++) tick();
    repeat (5) tick();
    check("drain", rx_q.size(), 0);
  endtask

  task automatic bus_read(input string tag, input logic [31:0] exp);
    check(tag, dat, exp);
    stb = 1'b1;
    we  = 1'b0;
    #1;
    check({tag, "_ack"}, {31'b0, ack}, 32'd1);
    tick();
    stb = 1'b0;
    tick();
  endtask

  task automatic bus_write(input logic [31:0] v);
    stb = 1'b1;
    we  = 1'b1;
    din = v;
    tick();
    stb = 1'b0;
    we  = 1'b0;
    din = 32'h0;
  endtask

  initial begin
    clrn = 1'b0;
    stb  = 1'b0;
    we   = 1'b0;
    din  = 32'h0;
    rx_drive();
    repeat (3) tick();
    check("rst_dat", dat, 32'h0);
    check("rst_int", {31'b0, int_o}, 32'd0);
    check("rst_rdn", {31'b0, code_rdn}, 32'd1);
    check("rst_ack", {31'b0, ack}, 32'd0);
    clrn = 1'b1;
    tick();

    // Single key with interrupts enabled, checking pop and push timing
    bus_write(32'h2);
    tick();
    feed(8'h1C);
    tick();
    check("t1_rdn_low", {31'b0, code_rdn}, 32'd0);
    tick();
    check("t1_rdn_high", {31'b0, code_rdn}, 32'd1);
    check("t1_not_yet", dat, 32'h0);
    tick();
    check("t1_evt", dat, 32'h8000_611C);
    check("t1_int", {31'b0, int_o}, 32'd1);
    check("t1_pops", n_pops, 1);
    bus_read("t1_read", 32'h8000_611C);
    check("t1_empty", dat, 32'h0);
    check("t1_int_clr", {31'b0, int_o}, 32'd0);

    // Shift make/break around a letter
    feed(8'h12); feed(8'h1C); feed(8'hF0); feed(8'h1C); feed(8'hF0); feed(8'h12);
    wait_drain();
    bus_read("t2_e0", 32'h8004_0012);
    bus_read("t2_e1", 32'h8004_411C);
    bus_read("t2_e2", 32'h8005_001C);
    bus_read("t2_e3", 32'h8001_0012);
    check("t2_empty", dat, 32'h0);

    // Extended keys, ignored codes, digit and space
    feed(8'hE0); feed(8'h75); feed(8'hE0); feed(8'hF0); feed(8'h75);
    feed(8'hFA); feed(8'h1C); feed(8'h16); feed(8'h29);
    wait_drain();
    bus_read("t3_ext_make", 32'h8002_0075);
    bus_read("t3_ext_brk",  32'h8003_0075);
    bus_read("t3_after_fa", 32'h8000_611C);
    bus_read("t3_digit",    32'h8000_3116);
    bus_read("t3_space",    32'h8000_2029);
    check("t3_empty", dat, 32'h0);

    // Caps lock interacting with shift, then restore both
    feed(8'h58); feed(8'h1C); feed(8'h12); feed(8'h1C); feed(8'hF0); feed(8'h12); feed(8'h58);
    wait_drain();
    bus_read("t4_caps_on",  32'h8020_0058);
    bus_read("t4_caps_A",   32'h8020_411C);
    bus_read("t4_shift",    32'h8024_0012);
    bus_read("t4_caps_a",   32'h8024_611C);
    bus_read("t4_shift_up", 32'h8021_0012);
    bus_read("t4_caps_off", 32'h8000_0058);
    check("t4_empty", dat, 32'h0);

    // Nine codes with no reads: the ninth must wait in the receiver
    n_pops = 0;
    for (int i = 0; i < 9; i++) feed(burst_codes[i]);
    repeat (60) tick();
    check("t5_pops_full", n_pops, 8);
    check("t5_ready_held", {31'b0, code_ready}, 32'd1);
    check("t5_head", dat, burst_evts[0]);
    stb = 1'b1;
    we  = 1'b0;
    repeat (3) tick();
    stb = 1'b0;
    repeat (10) tick();
    check("t5_pops_after", n_pops, 9);
    check("t5_ready_clr", {31'b0, code_ready}, 32'd0);
    for (int i = 1; i < 4; i++) bus_read($sformatf("t5_evt%0d", i), burst_evts[i]);
    check("t5_head5", dat, burst_evts[4]);

    // Flush with five events pending
    bus_write(32'h3);
    check("t6_flush_dat", dat, 32'h0);
    check("t6_flush_int", {31'b0, int_o}, 32'd0);
    tick();

    // Reset in POP drops a pending break prefix
    feed(8'hF0);
    wait_drain();
    feed(8'h1C);
    tick();
    check("t7_rdn_low", {31'b0, code_rdn}, 32'd0);
    clrn = 1'b0;
    tick();
    check("t7_rst_rdn", {31'b0, code_rdn}, 32'd1);
    check("t7_rst_dat", dat, 32'h0);
    check("t7_rst_int", {31'b0, int_o}, 32'd0);
    clrn = 1'b1;
    tick();
    bus_write(32'h2);
    tick();
    feed(8'h1C);
    wait_drain();
    check("t7_int", {31'b0, int_o}, 32'd1);
    bus_read("t7_no_brk", 32'h8000_611C);
    check("t7_empty", dat, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
